qed_dup_scheduler: RTL and testbench

QED_DUP_SCHEDULER -- requirements
Module: qed_dup_scheduler

---
 rtl/qed_dup_scheduler.sv | 127 ++++++++++++
 tb/tb_qed_dup_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_scheduler.sv
// rtl/qed_dup_scheduler.sv - QED original/duplicate instruction scheduler
// Originals pass straight through and are queued; duplicates replay the queue in order.
module qed_dup_scheduler #(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exec_dup,
  input  logic          force_dup,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic          out_is_dup,
  input  logic          out_ready,
  output logic [CW-1:0] qed_num_orig,
  output logic [CW-1:0] qed_num_dup,
  output logic          qed_ready,
  output logic [1:0]    sif_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ORIG = 2'd1,
    DUP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   orig_q, orig_d, dup_q, dup_d;
  logic            qed_ready_q, qed_ready_d;
  logic [IW-1:0]   mem_q [DEPTH];
  logic            wr_en;
  logic            hs;
  logic            empty, full;

  function automatic logic is_empty(input logic [AW:0] h, input logic [AW:0] t);
    return h == t;
  endfunction

  function automatic logic is_full(input logic [AW:0] h, input logic [AW:0] t);
    return (h[AW-1:0] == t[AW-1:0]) && (h[AW] != t[AW]);
  endfunction

  assign empty = is_empty(head_q, tail_q);
  assign full  = is_full(head_q, tail_q);

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    orig_d     = orig_q;
    dup_d      = dup_q;
    wr_en      = 1'b0;
    hs         = 1'b0;
    out_valid  = 1'b0;
    out_instr  = in_instr;
    out_is_dup = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        if (exec_dup) state_d = ORIG;
      end
      ORIG: begin
        out_valid = in_valid & ~full;
        in_ready  = out_ready & ~full;
        hs        = in_valid & ~full & out_ready;
        if (hs) begin
          wr_en  = 1'b1;
          tail_d = tail_q + 1'b1;
          orig_d = (orig_q == '1) ? orig_q : orig_q + 1'b1;
        end
        // Phase decisions look at the queue as it stands after this edge's write.
        if (is_full(head_q, tail_d)) state_d = DUP;
        else if (!exec_dup) state_d = is_empty(head_q, tail_d) ? IDLE : DUP;
        else if (force_dup && !is_empty(head_q, tail_d)) state_d = DUP;
      end
      DUP: begin
        out_valid  = ~empty;
        out_instr  = mem_q[head_q[AW-1:0]];
        out_is_dup = 1'b1;
        hs         = ~empty & out_ready;
        if (hs) begin
          head_d = head_q + 1'b1;
          dup_d  = (dup_q == '1) ? dup_q : dup_q + 1'b1;
        end
        if (is_empty(head_d, tail_q)) state_d = exec_dup ? ORIG : IDLE;
      end
      default: state_d = IDLE;
    endcase
    qed_ready_d = (state_q == IDLE || state_q == ORIG) && empty &&
                  (orig_q == dup_q) && (orig_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      orig_q      <= '0;
      dup_q       <= '0;
      qed_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      orig_q      <= orig_d;
      dup_q       <= dup_d;
      qed_ready_q <= qed_ready_d;
      if (wr_en) mem_q[tail_q[AW-1:0]] <= in_instr;
    end
  end

  assign qed_num_orig = orig_q;
  assign qed_num_dup  = dup_q;
  assign qed_ready    = qed_ready_q;
  assign sif_state    = state_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb/tb_qed_dup_scheduler.sv - scoreboard bench for qed_dup_scheduler
// Expected issue stream is queued by the stimulus; a negedge monitor pops and compares.
module tb_qed_dup_scheduler;

  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          exec_dup, force_dup, in_valid, out_ready;
  logic [IW-1:0] in_instr;
  logic          in_ready, out_valid, out_is_dup, qed_ready;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] qed_num_orig, qed_num_dup;
  logic [1:0]    sif_state;

  int errors = 0;
  int checks = 0;
  int dup_seen = 0;
  bit watch_dup = 1'b0;
  logic [IW:0] sb [$];

  qed_dup_scheduler #(.DEPTH(DEPTH), .IW(IW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .exec_dup(exec_dup), .force_dup(force_dup),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_is_dup(out_is_dup),
    .out_ready(out_ready), .qed_num_orig(qed_num_orig), .qed_num_dup(qed_num_dup),
    .qed_ready(qed_ready), .sif_state(sif_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && watch_dup && out_valid && out_is_dup) dup_seen++;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got dup=%0b instr=%0h expected nothing", out_is_dup, out_instr);
      end else begin
        logic [IW:0] exp;
        exp = sb.pop_front();
        if ({out_is_dup, out_instr} != exp) begin
          errors++;
          $display("FAIL issue: got dup=%0b instr=%0h expected dup=%0b instr=%0h",
                   out_is_dup, out_instr, exp[IW], exp[IW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    exec_dup = 1'b0; force_dup = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] v);
    int n;
    sb.push_back({1'b0, v});
    in_valid = 1'b1;
    in_instr = v;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_dups(input logic [IW-1:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back({1'b1, base + IW'(i)});
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    int n;
    n = 0;
    while (sif_state != s && n < max) begin
      step();
      n++;
    end
    chk(name, sif_state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; exec_dup = 1'b0; force_dup = 1'b0; in_valid = 1'b0;
    in_instr = '0; out_ready = 1'b0;
    #3;
    chk("rst_state", sif_state, 0);
    chk("rst_orig", qed_num_orig, 0);
    chk("rst_dup", qed_num_dup, 0);
    chk("rst_qed_ready", qed_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pass-through with sequencing disabled
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'hA000_0000 + IW'(i));
    in_valid = 1'b0;
    step();
    chk("pt_orig", qed_num_orig, 0);
    chk("pt_dup", qed_num_dup, 0);
    chk("pt_state", sif_state, 0);

    // Fill the queue, then replay all 8
    do_reset();
    exec_dup = 1'b1;
    step();
    chk("fill_enter_orig", sif_state, 1);
    for (int i = 0; i < 8; i++) send(32'hB000_0000 + IW'(i));
    chk("fill_state_dup", sif_state, 2);
    in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
    #1 chk("fill_in_ready", in_ready, 0);
    in_valid = 1'b0;
    push_dups(32'hB000_0000, 8);
    wait_state(2'd1, 40, "fill_back_orig");
    repeat (2) step();
    chk("fill_qed_ready", qed_ready, 1);
    chk("fill_orig", qed_num_orig, 8);
    chk("fill_dup", qed_num_dup, 8);

    // force_dup: ignored on empty queue, honoured after 3 originals
    do_reset();
    exec_dup = 1'b1;
    step();
    force_dup = 1'b1;
    step();
    force_dup = 1'b0;
    chk("force_empty_ignored", sif_state, 1);
    for (int i = 0; i < 3; i++) send(32'hC000_0000 + IW'(i));
    in_valid = 1'b0;
    force_dup = 1'b1;
    step();
    force_dup = 1'b0;
    chk("force_state_dup", sif_state, 2);
    push_dups(32'hC000_0000, 3);
    wait_state(2'd1, 20, "force_back_orig");
    repeat (2) step();
    chk("force_qed_ready", qed_ready, 1);
    chk("force_orig", qed_num_orig, 3);
    chk("force_dup", qed_num_dup, 3);

    // Backpressure during replay: 1,0,0,1
    do_reset();
    exec_dup = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(32'hD000_0000 + IW'(i));
    in_valid = 1'b0;
    force_dup = 1'b1;
    step();
    force_dup = 1'b0;
    push_dups(32'hD000_0000, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("stall1_valid", out_valid, 1);
    chk("stall1_instr", out_instr, 32'hD000_0001);
    step();
    chk("stall2_valid", out_valid, 1);
    chk("stall2_instr", out_instr, 32'hD000_0001);
    chk("stall2_is_dup", out_is_dup, 1);
    step();
    out_ready = 1'b1;
    wait_state(2'd1, 20, "stall_back_orig");
    chk("stall_dup_cnt", qed_num_dup, 4);

    // exec_dup drop after 5 originals still drains all 5
    do_reset();
    exec_dup = 1'b1;
    step();
    for (int i = 0; i < 5; i++) send(32'hE000_0000 + IW'(i));
    in_valid = 1'b0;
    exec_dup = 1'b0;
    push_dups(32'hE000_0000, 5);
    step();
    chk("drop_state_dup", sif_state, 2);
    wait_state(2'd0, 20, "drop_idle");
    chk("drop_orig", qed_num_orig, 5);
    chk("drop_dup", qed_num_dup, 5);
    step();
    chk("drop_qed_ready", qed_ready, 1);

    // Asynchronous reset mid-replay discards the queue
    do_reset();
    exec_dup = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(32'hF000_0000 + IW'(i));
    in_valid = 1'b0;
    out_ready = 1'b0;
    force_dup = 1'b1;
    step();
    force_dup = 1'b0;
    chk("arst_pre_state", sif_state, 2);
    chk("arst_pre_is_dup", out_is_dup, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", sif_state, 0);
    chk("arst_orig", qed_num_orig, 0);
    chk("arst_dup", qed_num_dup, 0);
    chk("arst_qed_ready", qed_ready, 0);
    chk("arst_is_dup", out_is_dup, 0);
    chk("arst_out_valid", out_valid, 0);
    exec_dup = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    watch_dup = 1'b1;
    repeat (10) step();
    watch_dup = 1'b0;
    chk("arst_no_dup_after", dup_seen, 0);
    chk("arst_state_idle", sif_state, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
